// File: rtl/ttt_scoreboard.sv
// ttt_scoreboard: rebuilds a 3x3 shadow board from the tictactoe core's
// serial cell stream, classifies each committed frame, and keeps saturating
// X-win / O-win / draw tallies. A game is counted once: the same nonzero
// result must repeat for CONFIRM frames, then further frames are ignored
// until an all-empty board is seen.
// Optional feature: define TTT_STREAK_EN to add streak_player/streak_len.
module ttt_scoreboard #(
  parameter int SCORE_W = 8,
  parameter int CONFIRM = 2
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               cell_valid,
  input  logic [1:0]         row_in,
  input  logic [1:0]         col_in,
  input  logic [1:0]         xoro_in,
  input  logic [1:0]         win_in,
  input  logic               clear_scores,
  output logic [17:0]        board,
  output logic               frame_done,
  output logic               game_over,
  output logic [SCORE_W-1:0] x_wins,
  output logic [SCORE_W-1:0] o_wins,
  output logic [SCORE_W-1:0] draws,
  output logic               frame_err
`ifdef TTT_STREAK_EN
  ,
  output logic [1:0]         streak_player,
  output logic [SCORE_W-1:0] streak_len
`endif
);

  localparam int CNT_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_X    = 2'd1;
  localparam logic [1:0] RES_O    = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  typedef enum logic [1:0] {S_PLAY, S_CONF, S_OVER} state_t;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0]         r_idx;
  logic [17:0]        r_buf;
  logic [17:0]        r_board;
  logic               r_frame_done;
  logic               r_frame_err;
  logic               r_game_over;
  logic [SCORE_W-1:0] r_x_wins;
  logic [SCORE_W-1:0] r_o_wins;
  logic [SCORE_W-1:0] r_draws;
  state_t             r_state;
  logic [1:0]         r_cand;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_illegal;
  logic [3:0]         w_cell_idx;
  logic               w_match;
  logic               w_mismatch;
  logic               w_commit;
  logic               w_cell00;
  logic [17:0]        w_frame;
  logic               w_full;
  logic               w_empty;
  logic [1:0]         w_res;
  state_t             w_state_nx;
  logic [1:0]         w_cand_nx;
  logic [CNT_W-1:0]   w_cnt_nx;
  logic               w_count;

  assign w_illegal  = (row_in == 2'd3) | (col_in == 2'd3) |
                      (xoro_in == 2'd3) | (win_in == 2'd3);
  assign w_cell_idx = {1'b0, row_in, 1'b0} + {2'b00, row_in} + {2'b00, col_in};
  assign w_match    = cell_valid & ~w_illegal & (w_cell_idx == r_idx);
  assign w_mismatch = cell_valid & ~w_match;
  assign w_commit   = w_match & (r_idx == 4'd8);
  assign w_cell00   = (row_in == 2'd0) & (col_in == 2'd0);
  // The frame being committed: buffered cells 0..7 plus the (2,2) cell now on the bus
  assign w_frame    = {xoro_in, r_buf[15:0]};

  // Occupancy of the committing frame (full -> draw candidate, empty -> new game)
  always_comb begin
    w_full  = 1'b1;
    w_empty = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (w_frame[2*i +: 2] == 2'd0) w_full  = 1'b0;
      else                           w_empty = 1'b0;
    end
  end

  // Frame result from the core's win code and board occupancy
  always_comb begin
    w_res = RES_NONE;
    if (win_in == 2'd1)      w_res = RES_X;
    else if (win_in == 2'd2) w_res = RES_O;
    else if (w_full)         w_res = RES_DRAW;
  end

  // Scan index, working buffer, board commit and sticky error flag
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_idx        <= 4'd0;
      r_buf        <= 18'd0;
      r_board      <= 18'd0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      if (w_match) begin
        for (int i = 0; i < 9; i++) begin
          if (r_idx == 4'(i)) r_buf[2*i +: 2] <= xoro_in;
        end
        if (w_commit) begin
          r_idx   <= 4'd0;
          r_board <= w_frame;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end else if (w_mismatch) begin
        r_frame_err <= 1'b1;
        // A stray (0,0) is taken as the start of a fresh frame
        if (w_cell00) begin
          r_idx <= 4'd1;
          r_buf <= {16'd0, (xoro_in == 2'd3) ? 2'd0 : xoro_in};
        end else begin
          r_idx <= 4'd0;
          r_buf <= 18'd0;
        end
      end
    end
  end

  // Game FSM state register
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_state <= S_PLAY;
      r_cand  <= RES_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Game FSM next state; only a committing frame advances it
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_count    = 1'b0;
    if (w_commit) begin
      case (r_state)
        S_PLAY: begin
          if (w_res != RES_NONE) begin
            w_cand_nx = w_res;
            w_cnt_nx  = CNT_W'(1);
            if (CONFIRM <= 1) begin
              w_count    = 1'b1;
              w_state_nx = S_OVER;
            end else begin
              w_state_nx = S_CONF;
            end
          end
        end
        S_CONF: begin
          if (w_res == RES_NONE) begin
            w_state_nx = S_PLAY;
          end else if (w_res == r_cand) begin
            w_cnt_nx = r_cnt + 1'b1;
            if (w_cnt_nx == CNT_W'(CONFIRM)) begin
              w_count    = 1'b1;
              w_state_nx = S_OVER;
            end
          end else begin
            w_cand_nx = w_res;
            w_cnt_nx  = CNT_W'(1);
          end
        end
        S_OVER: begin
          if (w_empty) w_state_nx = S_PLAY;
        end
        default: w_state_nx = S_PLAY;
      endcase
    end
  end

  // Tallies and game_over pulse; clear_scores overrides a simultaneous count
  always_ff @(posedge ph1) begin
    if (reset) begin
      r_game_over <= 1'b0;
      r_x_wins    <= '0;
      r_o_wins    <= '0;
      r_draws     <= '0;
    end else begin
      r_game_over <= w_count;
      if (clear_scores) begin
        r_x_wins <= '0;
        r_o_wins <= '0;
        r_draws  <= '0;
      end else if (w_count) begin
        case (w_cand_nx)
          RES_X:    r_x_wins <= sat_inc(r_x_wins);
          RES_O:    r_o_wins <= sat_inc(r_o_wins);
          RES_DRAW: r_draws  <= sat_inc(r_draws);
          default:  ;
        endcase
      end
    end
  end

`ifdef TTT_STREAK_EN
  logic [1:0]         r_streak_player;
  logic [SCORE_W-1:0] r_streak_len;

  // Consecutive counted wins by one player; a draw breaks the streak
  always_ff @(posedge ph1) begin
    if (reset || clear_scores) begin
      r_streak_player <= 2'd0;
      r_streak_len    <= '0;
    end else if (w_count) begin
      if (w_cand_nx == RES_DRAW) begin
        r_streak_player <= 2'd0;
        r_streak_len    <= '0;
      end else if (r_streak_player == w_cand_nx) begin
        r_streak_len <= sat_inc(r_streak_len);
      end else begin
        r_streak_player <= w_cand_nx;
        r_streak_len    <= SCORE_W'(1);
      end
    end
  end

  assign streak_player = r_streak_player;
  assign streak_len    = r_streak_len;
`endif

  assign board      = r_board;
  assign frame_done = r_frame_done;
  assign game_over  = r_game_over;
  assign x_wins     = r_x_wins;
  assign o_wins     = r_o_wins;
  assign draws      = r_draws;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ttt_scoreboard.sv
// Testbench for ttt_scoreboard: directed game sequences, a vector table for
// scan-order errors, and randomized frame streams against a reference model.
module tb_ttt_scoreboard;

  localparam int SCORE_W = 8;
  localparam int CONFIRM = 2;
  localparam int MAXS    = (1 << SCORE_W) - 1;

  logic               ph1 = 1'b0;
  logic               reset = 1'b0;
  logic               cell_valid = 1'b0;
  logic [1:0]         row_in = 2'd0;
  logic [1:0]         col_in = 2'd0;
  logic [1:0]         xoro_in = 2'd0;
  logic [1:0]         win_in = 2'd0;
  logic               clear_scores = 1'b0;
  logic [17:0]        board;
  logic               frame_done;
  logic               game_over;
  logic [SCORE_W-1:0] x_wins;
  logic [SCORE_W-1:0] o_wins;
  logic [SCORE_W-1:0] draws;
  logic               frame_err;
`ifdef TTT_STREAK_EN
  logic [1:0]         streak_player;
  logic [SCORE_W-1:0] streak_len;
`endif

  ttt_scoreboard #(.SCORE_W(SCORE_W), .CONFIRM(CONFIRM)) dut (
    .ph1(ph1), .reset(reset), .cell_valid(cell_valid),
    .row_in(row_in), .col_in(col_in), .xoro_in(xoro_in), .win_in(win_in),
    .clear_scores(clear_scores), .board(board), .frame_done(frame_done),
    .game_over(game_over), .x_wins(x_wins), .o_wins(o_wins), .draws(draws),
    .frame_err(frame_err)
`ifdef TTT_STREAK_EN
    , .streak_player(streak_player), .streak_len(streak_len)
`endif
  );

  always #5 ph1 = ~ph1;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;
  int go_seen  = 0;

  // Reference model: game results tracked as "run of identical results"
  int       m_idx;
  int       m_buf[9];
  int       m_board[9];
  bit       m_fd, m_go, m_err, m_over;
  int       m_x, m_o, m_d;
  int       m_run_res, m_run_len;
  int       m_sp, m_sl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= MAXS) ? MAXS : v + 1;
  endfunction

  task automatic judge(input int res, input bit empty);
    if (m_over) begin
      if (empty) begin
        m_over    = 1'b0;
        m_run_len = 0;
      end
    end else if (res == 0) begin
      m_run_len = 0;
    end else begin
      if (m_run_len > 0 && res == m_run_res) m_run_len++;
      else begin
        m_run_res = res;
        m_run_len = 1;
      end
      if (m_run_len >= CONFIRM) begin
        m_go      = 1'b1;
        m_over    = 1'b1;
        m_run_len = 0;
        if (res == 1) m_x = sat(m_x);
        else if (res == 2) m_o = sat(m_o);
        else m_d = sat(m_d);
        if (res == 3) begin
          m_sp = 0;
          m_sl = 0;
        end else if (m_sp == res) m_sl = sat(m_sl);
        else begin
          m_sp = res;
          m_sl = 1;
        end
      end
    end
  endtask

  task automatic model(input bit rst, input bit v, input logic [1:0] r, input logic [1:0] c,
                       input logic [1:0] x, input logic [1:0] w, input bit clr);
    bit full, empty;
    int res;
    m_fd = 1'b0;
    m_go = 1'b0;
    if (rst) begin
      m_idx = 0; m_err = 0; m_over = 0; m_x = 0; m_o = 0; m_d = 0;
      m_run_res = 0; m_run_len = 0; m_sp = 0; m_sl = 0;
      for (int i = 0; i < 9; i++) begin m_buf[i] = 0; m_board[i] = 0; end
      return;
    end
    if (v) begin
      if (r != 3 && c != 3 && x != 3 && w != 3 && (int'(r) * 3 + int'(c)) == m_idx) begin
        m_buf[m_idx] = int'(x);
        if (m_idx == 8) begin
          m_idx = 0;
          m_fd  = 1'b1;
          full  = 1'b1;
          empty = 1'b1;
          for (int i = 0; i < 9; i++) begin
            m_board[i] = m_buf[i];
            if (m_buf[i] == 0) full = 1'b0; else empty = 1'b0;
          end
          res = (w == 1) ? 1 : (w == 2) ? 2 : full ? 3 : 0;
          judge(res, empty);
        end else begin
          m_idx++;
        end
      end else begin
        m_err = 1'b1;
        for (int i = 0; i < 9; i++) m_buf[i] = 0;
        if (r == 0 && c == 0) begin
          m_idx = 1;
          if (x != 3) m_buf[0] = int'(x);
        end else begin
          m_idx = 0;
        end
      end
    end
    if (clr) begin
      m_x = 0; m_o = 0; m_d = 0; m_sp = 0; m_sl = 0;
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_board[i]);
    return b;
  endfunction

  task automatic step(input bit v, input logic [1:0] r, input logic [1:0] c,
                      input logic [1:0] x, input logic [1:0] w, input bit clr);
    cell_valid   = v;
    row_in       = r;
    col_in       = c;
    xoro_in      = x;
    win_in       = w;
    clear_scores = clr;
    @(posedge ph1);
    #1;
    model(reset, v, r, c, x, w, clr);
    chk("board", board, model_board());
    chk("frame_done", frame_done, m_fd);
    chk("game_over", game_over, m_go);
    chk("x_wins", x_wins, m_x);
    chk("o_wins", o_wins, m_o);
    chk("draws", draws, m_d);
    chk("frame_err", frame_err, m_err);
`ifdef TTT_STREAK_EN
    chk("streak_player", streak_player, m_sp);
    chk("streak_len", streak_len, m_sl);
`endif
    if (frame_done) fd_seen++;
    if (game_over)  go_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [17:0] f, input logic [1:0] w, input bit clr_last);
    for (int i = 0; i < 9; i++)
      step(1, 2'(i / 3), 2'(i % 3), f[2*i +: 2], w, clr_last && (i == 8));
  endtask

  function automatic logic [17:0] pk(input int c0, input int c1, input int c2,
                                     input int c3, input int c4, input int c5,
                                     input int c6, input int c7, input int c8);
    return {2'(c8), 2'(c7), 2'(c6), 2'(c5), 2'(c4), 2'(c3), 2'(c2), 2'(c1), 2'(c0)};
  endfunction

  typedef struct {
    bit         v;
    logic [1:0] r, c, x, w;
    bit         clr;
    bit         e_fd, e_go, e_err;
  } vec_t;

  vec_t tbl[14];

  logic [17:0] F_EMPTY, F_XROW, F_OWIN, F_DRAW;

  initial begin
    F_EMPTY = '0;
    F_XROW  = pk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    F_OWIN  = pk(0, 0, 0, 2, 2, 2, 1, 1, 0);
    F_DRAW  = pk(1, 2, 1, 1, 2, 2, 2, 1, 1);

    tbl[0]  = '{1, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0, 0, 0};
    tbl[1]  = '{1, 2'd0, 2'd1, 2'd2, 2'd0, 0, 0, 0, 0};
    tbl[2]  = '{1, 2'd1, 2'd1, 2'd1, 2'd0, 0, 0, 0, 1};
    tbl[3]  = '{0, 2'd2, 2'd2, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[4]  = '{1, 2'd0, 2'd0, 2'd1, 2'd0, 0, 0, 0, 1};
    tbl[5]  = '{1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[6]  = '{1, 2'd0, 2'd2, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[7]  = '{0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[8]  = '{1, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[9]  = '{1, 2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[10] = '{1, 2'd1, 2'd2, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[11] = '{1, 2'd2, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[12] = '{1, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 1};
    tbl[13] = '{1, 2'd2, 2'd2, 2'd0, 2'd0, 0, 1, 0, 1};

    // Reset state
    do_reset();
    chk("rst_board", board, 18'd0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_go", game_over, 1'b0);
    chk("rst_tally", {x_wins, o_wins, draws}, '0);
    chk("rst_err", frame_err, 1'b0);

    // Empty frame: one commit, nothing counted
    fd_seen = 0; go_seen = 0;
    send_frame(F_EMPTY, 2'd0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_fd_once", fd_seen, 1);
    chk("t1_go", go_seen, 0);
    chk("t1_board", board, 18'd0);

    // X win needs two frames, then is not recounted
    go_seen = 0;
    send_frame(F_XROW, 2'd1, 0);
    chk("t2_go_first", go_seen, 0);
    chk("t2_board", board, 18'h15);
    send_frame(F_XROW, 2'd1, 0);
    chk("t2_go_second", game_over, 1'b1);
    chk("t2_x1", x_wins, 8'd1);
    send_frame(F_XROW, 2'd1, 0);
    send_frame(F_XROW, 2'd1, 0);
    chk("t2_x_hold", x_wins, 8'd1);
    chk("t2_go_total", go_seen, 1);
    send_frame(F_EMPTY, 2'd0, 0);
    send_frame(F_OWIN, 2'd2, 0);
    send_frame(F_OWIN, 2'd2, 0);
    chk("t2_o1", o_wins, 8'd1);
    send_frame(F_EMPTY, 2'd0, 0);

    // Draws, and a draw followed by an X win restarts confirmation
    send_frame(F_DRAW, 2'd0, 0);
    send_frame(F_DRAW, 2'd0, 0);
    chk("t3_draw1", draws, 8'd1);
    send_frame(F_EMPTY, 2'd0, 0);
    go_seen = 0;
    send_frame(F_DRAW, 2'd0, 0);
    send_frame(F_XROW, 2'd1, 0);
    chk("t3_no_count", go_seen, 0);
    chk("t3_x_still1", x_wins, 8'd1);
    send_frame(F_XROW, 2'd1, 0);
    chk("t3_x2", x_wins, 8'd2);
    chk("t3_draw_still1", draws, 8'd1);
    send_frame(F_EMPTY, 2'd0, 0);

    // Scan-order error and recovery, vector table
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].x, tbl[i].w, tbl[i].clr);
      chk($sformatf("tbl%0d_fd", i), frame_done, tbl[i].e_fd);
      chk($sformatf("tbl%0d_go", i), game_over, tbl[i].e_go);
      chk($sformatf("tbl%0d_err", i), frame_err, tbl[i].e_err);
    end
    chk("tbl_board", board, 18'h1);

    // Reset mid-frame drops the partial frame
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    do_reset();
    chk("midrst_err", frame_err, 1'b0);
    chk("midrst_tally", {x_wins, o_wins, draws}, '0);
    send_frame(F_OWIN, 2'd0, 0);
    chk("midrst_board", board, F_OWIN);

    // Saturation and clear_scores against a simultaneous count
    do_reset();
    for (int g = 0; g < MAXS; g++) begin
      send_frame(F_XROW, 2'd1, 0);
      send_frame(F_XROW, 2'd1, 0);
      send_frame(F_EMPTY, 2'd0, 0);
    end
    chk("t5_x255", x_wins, 8'd255);
    go_seen = 0;
    send_frame(F_XROW, 2'd1, 0);
    send_frame(F_XROW, 2'd1, 0);
    chk("t5_sat_go", go_seen, 1);
    chk("t5_sat", x_wins, 8'd255);
    send_frame(F_EMPTY, 2'd0, 0);
    send_frame(F_XROW, 2'd1, 0);
    send_frame(F_XROW, 2'd1, 1);
    chk("t5_clr_x", x_wins, 8'd0);
    chk("t5_clr_go", game_over, 1'b1);
    send_frame(F_EMPTY, 2'd0, 0);

`ifdef TTT_STREAK_EN
    do_reset();
    send_frame(F_XROW, 2'd1, 0); send_frame(F_XROW, 2'd1, 0);
    chk("t6_len1", streak_len, 1); chk("t6_pl1", streak_player, 2'd1);
    send_frame(F_EMPTY, 2'd0, 0);
    send_frame(F_XROW, 2'd1, 0); send_frame(F_XROW, 2'd1, 0);
    chk("t6_len2", streak_len, 2); chk("t6_pl2", streak_player, 2'd1);
    send_frame(F_EMPTY, 2'd0, 0);
    send_frame(F_OWIN, 2'd2, 0); send_frame(F_OWIN, 2'd2, 0);
    chk("t6_len3", streak_len, 1); chk("t6_pl3", streak_player, 2'd2);
    send_frame(F_EMPTY, 2'd0, 0);
    send_frame(F_DRAW, 2'd0, 0); send_frame(F_DRAW, 2'd0, 0);
    chk("t6_len4", streak_len, 0); chk("t6_pl4", streak_player, 2'd0);
`endif

    // Randomized frame streams with gaps, errors and clears
    do_reset();
    for (int n = 0; n < 220; n++) begin
      logic [17:0] f;
      logic [1:0]  w;
      int          kind, reps;
      kind = int'($urandom_range(0, 9));
      f = '0;
      w = 2'd0;
      if (kind == 1) begin
        for (int i = 0; i < 9; i++) f[2*i +: 2] = 2'($urandom_range(1, 2));
      end else if (kind != 0) begin
        for (int i = 0; i < 9; i++) f[2*i +: 2] = 2'($urandom_range(0, 2));
        w = 2'($urandom_range(0, 2));
      end
      reps = int'($urandom_range(1, 3));
      for (int k = 0; k < reps; k++) begin
        for (int i = 0; i < 9; i++) begin
          if ($urandom_range(0, 19) == 0) step(0, 0, 0, 0, 0, 0);
          if ($urandom_range(0, 59) == 0)
            step(1, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0);
          else
            step(1, 2'(i / 3), 2'(i % 3), f[2*i +: 2], w, $urandom_range(0, 99) == 0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
